vote_session_ctrl: RTL

Sequencing controller for a 7-seat majority voter. Opens a voting session on request, collects at most one vote per seat through per-seat valid strobes, and closes the session when every seat has voted or the collection window expires. Then tallies the votes and presents a held majority result until the consumer acknowledges it. Sits between the seat inputs and downstream logic; it owns the tally datapath and is its only sequencer.

---
 rtl/vote_session_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/vote_session_ctrl.sv
// -----------------------------------------------------------------------------
// vote_session_ctrl
//
// Sequencing controller for an N_VOTERS-seat majority voter. A session opens
// on a start request, collects at most one vote per seat, and closes once
// every seat has voted (or, with the timeout feature, once the collection
// window expires). The held votes are then tallied and the majority result is
// presented until the consumer acknowledges it.
//
// Optional feature macro: VOTE_TIMEOUT_EN
//   defined   : COLLECT also exits after TIMEOUT_CYC cycles, setting timed_out
//               when not every seat has voted.
//   undefined : no timer logic; COLLECT exits only on completion and
//               timed_out stays 0.
//
// Ports:
//   clk          in   1         rising-edge clock
//   rst          in   1         synchronous reset, active-high
//   start        in   1         open a session (sampled only in IDLE)
//   vote_valid   in   N_VOTERS  per-seat vote strobe
//   vote_val     in   N_VOTERS  per-seat vote value (1 = yes)
//   busy         out  1         controller is not idle
//   result_valid out  1         tally result held until result_ack
//   result_ack   in   1         consumer acknowledge (used only in RESULT)
//   result       out  1         yes_count >= THRESHOLD
//   yes_count    out  CNT_W     accepted yes votes
//   voted_count  out  CNT_W     seats that voted
//   timed_out    out  1         session closed by timeout before completion
//   dup_err      out  1         sticky: a seat strobed again after voting
// -----------------------------------------------------------------------------
module vote_session_ctrl #(
  parameter int N_VOTERS    = 7,
  parameter int THRESHOLD   = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ack,
  output logic                result,
  output logic [CNT_W-1:0]    yes_count,
  output logic [CNT_W-1:0]    voted_count,
  output logic                timed_out,
  output logic                dup_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_TALLY   = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  localparam logic [31:0] THR_C = 32'(THRESHOLD);

  // Number of set bits in a seat vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTERS-1:0] bits);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < N_VOTERS; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
    return cnt;
  endfunction

  state_t               state_q, state_d;
  logic [N_VOTERS-1:0]  voted_mask_q, voted_mask_d;
  logic [N_VOTERS-1:0]  yes_bits_q, yes_bits_d;
  logic                 busy_q, busy_d;
  logic                 result_valid_q, result_valid_d;
  logic                 result_q, result_d;
  logic [CNT_W-1:0]     yes_count_q, yes_count_d;
  logic [CNT_W-1:0]     voted_count_q, voted_count_d;
  logic                 timed_out_q, timed_out_d;
  logic                 dup_err_q, dup_err_d;

  // Seats accepted this cycle, seats re-strobing, and the mask after accepts.
  logic [N_VOTERS-1:0]  new_accept_s;
  logic [N_VOTERS-1:0]  dup_hit_s;
  logic [N_VOTERS-1:0]  mask_next_s;
  logic [CNT_W-1:0]     yes_pop_s;
  logic                 timeout_hit_s;

  assign new_accept_s = vote_valid & ~voted_mask_q;
  assign dup_hit_s    = vote_valid & voted_mask_q;
  assign mask_next_s  = voted_mask_q | vote_valid;
  // yes_bits only ever holds accepted seats, the mask keeps that explicit.
  assign yes_pop_s    = popcount(yes_bits_q & voted_mask_q);

`ifdef VOTE_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  assign timeout_hit_s = (timer_q == TMR_LAST);

  // Collection-window timer: cleared on session open, counts COLLECT cycles.
  always_comb begin
    timer_d = timer_q;
    if (state_q == S_IDLE) begin
      timer_d = {TMR_W{1'b0}};
    end else if (state_q == S_COLLECT) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= {TMR_W{1'b0}};
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and datapath update for the session sequencer.
  always_comb begin
    state_d       = state_q;
    voted_mask_d  = voted_mask_q;
    yes_bits_d    = yes_bits_q;
    result_d      = result_q;
    yes_count_d   = yes_count_q;
    voted_count_d = voted_count_q;
    timed_out_d   = timed_out_q;
    dup_err_d     = dup_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_COLLECT;
          voted_mask_d  = {N_VOTERS{1'b0}};
          yes_bits_d    = {N_VOTERS{1'b0}};
          result_d      = 1'b0;
          yes_count_d   = {CNT_W{1'b0}};
          voted_count_d = {CNT_W{1'b0}};
          timed_out_d   = 1'b0;
          dup_err_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COLLECT: begin
        voted_mask_d = mask_next_s;
        // Only first-time voters overwrite their yes bit.
        yes_bits_d   = (yes_bits_q & ~new_accept_s) | (vote_val & new_accept_s);
        if (|dup_hit_s) begin
          dup_err_d = 1'b1;
        end else begin
          dup_err_d = dup_err_q;
        end
        // Completion takes priority so a full house never reports a timeout.
        if (&mask_next_s) begin
          state_d = S_TALLY;
        end else if (timeout_hit_s) begin
          state_d     = S_TALLY;
          timed_out_d = 1'b1;
        end else begin
          state_d = S_COLLECT;
        end
      end

      S_TALLY: begin
        yes_count_d   = yes_pop_s;
        voted_count_d = popcount(voted_mask_q);
        result_d      = (32'(yes_pop_s) >= THR_C);
        state_d       = S_RESULT;
      end

      S_RESULT: begin
        if (result_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_RESULT);
  end

  // State, session datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      voted_mask_q   <= {N_VOTERS{1'b0}};
      yes_bits_q     <= {N_VOTERS{1'b0}};
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= 1'b0;
      yes_count_q    <= {CNT_W{1'b0}};
      voted_count_q  <= {CNT_W{1'b0}};
      timed_out_q    <= 1'b0;
      dup_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      voted_mask_q   <= voted_mask_d;
      yes_bits_q     <= yes_bits_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      yes_count_q    <= yes_count_d;
      voted_count_q  <= voted_count_d;
      timed_out_q    <= timed_out_d;
      dup_err_q      <= dup_err_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign yes_count    = yes_count_q;
  assign voted_count  = voted_count_q;
  assign timed_out    = timed_out_q;
  assign dup_err      = dup_err_q;

endmodule
